ft245_bus_bridge: RTL and testbench

//  Sequenced bridge between the 68000 bus and the FT245 USB FIFO serial port at 78000-7DFFF.

---
 rtl/ft245_bus_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_ft245_bus_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_bus_bridge.sv
// ft245_bus_bridge
//   Sequenced bridge between the 68000 bus and an FT245 USB FIFO. The CPU side
//   supplies already-decoded selects for serial in (rx), serial out (tx) and
//   serial status. The bridge times the FT245 _rd / wr strobes, waits for _txe
//   on writes (with a timeout), returns read data or status, and holds _dtack
//   low only once the access has really completed.
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   _as, _ds, rw        CPU strobes (async, active low) and read/write
//   sel_rx/tx/stat      decoded region selects, stable while _as is low
//   cpu_din, cpu_dout   CPU write data in / read data out
//   cpu_doe             drive enable for cpu_dout
//   _rdf, _txe          FT245 rx-available / tx-space flags (async, active low)
//   ft_din, ft_dout     FT245 data bus in / out
//   ft_doe              drive enable for ft_dout
//   _rd, wr             FT245 read strobe (active low), write strobe (active high)
//   _dtack              access complete to the CPU, active low
//   tx_drop             sticky: a tx byte was dropped on _txe timeout
module ft245_bus_bridge #(
  parameter int RD_CYCLES   = 3,
  parameter int WR_CYCLES   = 2,
  parameter int REC_CYCLES  = 2,
  parameter int TXE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       _as,
  input  logic       _ds,
  input  logic       rw,
  input  logic       sel_rx,
  input  logic       sel_tx,
  input  logic       sel_stat,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_doe,
  input  logic       _rdf,
  input  logic       _txe,
  input  logic [7:0] ft_din,
  output logic [7:0] ft_dout,
  output logic       ft_doe,
  output logic       _rd,
  output logic       wr,
  output logic       _dtack,
  output logic       tx_drop
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_WSETUP = 3'd2;
  localparam logic [2:0] S_WPULSE = 3'd3;
  localparam logic [2:0] S_WHOLD  = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;
  localparam logic [2:0] S_REC    = 3'd6;

  // Terminal counts: each timed state lasts exactly N cycles.
  localparam logic [7:0] RD_LAST  = 8'(RD_CYCLES - 1);
  localparam logic [7:0] WR_LAST  = 8'(WR_CYCLES - 1);
  localparam logic [7:0] REC_LAST = 8'(REC_CYCLES - 1);
  localparam logic [7:0] TO_LAST  = 8'(TXE_TIMEOUT - 1);

  logic [1:0] r_as_sync, r_ds_sync, r_rdf_sync, r_txe_sync;
  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic       r_rw;
  logic [7:0] r_cpu_dout, r_ft_dout;
  logic       r_cpu_doe, r_ft_doe, r_rd_n, r_wr, r_dtack_n, r_tx_drop;

  logic w_as_s, w_ds_s, w_rdf_s, w_txe_s;
  logic w_accept, w_drop_set, w_drop_clr;

  assign w_as_s  = r_as_sync[1];
  assign w_ds_s  = r_ds_sync[1];
  assign w_rdf_s = r_rdf_sync[1];
  assign w_txe_s = r_txe_sync[1];

  always_comb begin
    w_accept   = 1'b0;
    w_drop_set = 1'b0;
    w_drop_clr = 1'b0;
    w_accept   = (r_state == S_IDLE) && !w_as_s && !w_ds_s &&
                 (sel_rx || sel_tx || sel_stat);
    w_drop_set = (r_state == S_WSETUP) && w_txe_s && (r_cnt == TO_LAST);
    // Only a status read (stat selected alone after priority) clears the flag.
    w_drop_clr = w_accept && !sel_rx && !sel_tx && rw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_as_sync  <= 2'b11;
      r_ds_sync  <= 2'b11;
      r_rdf_sync <= 2'b11;
      r_txe_sync <= 2'b11;
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_rw       <= 1'b1;
      r_cpu_dout <= 8'h00;
      r_ft_dout  <= 8'h00;
      r_cpu_doe  <= 1'b0;
      r_ft_doe   <= 1'b0;
      r_rd_n     <= 1'b1;
      r_wr       <= 1'b0;
      r_dtack_n  <= 1'b1;
      r_tx_drop  <= 1'b0;
    end else begin
      r_as_sync  <= {r_as_sync[0], _as};
      r_ds_sync  <= {r_ds_sync[0], _ds};
      r_rdf_sync <= {r_rdf_sync[0], _rdf};
      r_txe_sync <= {r_txe_sync[0], _txe};
      // Set takes precedence over clear.
      r_tx_drop  <= w_drop_set | (r_tx_drop & ~w_drop_clr);

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rw  <= rw;
            r_cnt <= 8'd0;
            if (sel_rx) begin
              if (rw && !w_rdf_s) begin
                r_state <= S_RD;
                r_rd_n  <= 1'b0;
              end else begin
                r_state   <= S_ACK;
                r_dtack_n <= 1'b0;
                r_cpu_doe <= rw;
                if (rw) r_cpu_dout <= 8'hFF;   // FIFO empty
              end
            end else if (sel_tx) begin
              if (rw) begin
                r_state    <= S_ACK;
                r_dtack_n  <= 1'b0;
                r_cpu_doe  <= 1'b1;
                r_cpu_dout <= 8'hFF;
              end else begin
                r_state   <= S_WSETUP;
                r_ft_dout <= cpu_din;
                r_ft_doe  <= 1'b1;
              end
            end else begin
              r_state   <= S_ACK;
              r_dtack_n <= 1'b0;
              r_cpu_doe <= rw;
              if (rw) r_cpu_dout <= {5'b0, r_tx_drop, ~w_txe_s, ~w_rdf_s};
            end
          end
        end
        S_RD: begin
          if (r_cnt == RD_LAST) begin
            r_rd_n     <= 1'b1;
            r_cpu_dout <= ft_din;
            r_state    <= S_ACK;
            r_dtack_n  <= 1'b0;
            r_cpu_doe  <= r_rw;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WSETUP: begin
          if (!w_txe_s) begin
            r_state <= S_WPULSE;
            r_wr    <= 1'b1;
            r_cnt   <= 8'd0;
          end else if (r_cnt == TO_LAST) begin
            r_ft_doe  <= 1'b0;
            r_state   <= S_ACK;
            r_dtack_n <= 1'b0;
            r_cpu_doe <= r_rw;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WPULSE: begin
          if (r_cnt == WR_LAST) begin
            r_wr    <= 1'b0;
            r_state <= S_WHOLD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WHOLD: begin
          r_ft_doe  <= 1'b0;
          r_state   <= S_ACK;
          r_dtack_n <= 1'b0;
          r_cpu_doe <= r_rw;
        end
        S_ACK: begin
          // An aborted cycle already has as_s high, so this exits at once.
          if (w_as_s) begin
            r_dtack_n <= 1'b1;
            r_cpu_doe <= 1'b0;
            r_state   <= S_REC;
            r_cnt     <= 8'd0;
          end
        end
        S_REC: begin
          if (r_cnt == REC_LAST) r_state <= S_IDLE;
          else                   r_cnt   <= r_cnt + 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_dout = r_cpu_dout;
  assign cpu_doe  = r_cpu_doe;
  assign ft_dout  = r_ft_dout;
  assign ft_doe   = r_ft_doe;
  assign _rd      = r_rd_n;
  assign wr       = r_wr;
  assign _dtack   = r_dtack_n;
  assign tx_drop  = r_tx_drop;

endmodule

// File: tb/tb_ft245_bus_bridge.sv
// Testbench for ft245_bus_bridge. A transaction-level model turns each CPU
// access into expected per-edge output waveforms; one process compares the DUT
// against those waveforms on every cycle.
module tb_ft245_bus_bridge;
  localparam int RD = 3, WR = 2, REC = 2, TO = 255, MAXC = 20000;

  logic       clk = 1'b0, reset = 1'b1;
  logic       _as = 1'b1, _ds = 1'b1, rw = 1'b1;
  logic       sel_rx = 1'b0, sel_tx = 1'b0, sel_stat = 1'b0;
  logic       _rdf = 1'b1, _txe = 1'b1;
  logic [7:0] cpu_din = 8'h00, ft_din = 8'h00;
  logic [7:0] cpu_dout, ft_dout;
  logic       cpu_doe, ft_doe, _rd, wr, _dtack, tx_drop;

  ft245_bus_bridge dut (
    .clk(clk), .reset(reset), ._as(_as), ._ds(_ds), .rw(rw),
    .sel_rx(sel_rx), .sel_tx(sel_tx), .sel_stat(sel_stat),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_doe(cpu_doe),
    ._rdf(_rdf), ._txe(_txe), .ft_din(ft_din), .ft_dout(ft_dout),
    .ft_doe(ft_doe), ._rd(_rd), .wr(wr), ._dtack(_dtack), .tx_drop(tx_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected value of each output just after edge n.
  bit         e_rdn [MAXC];
  bit         e_wr  [MAXC];
  bit         e_dtn [MAXC];
  bit         e_fdoe[MAXC];
  bit         e_cdoe[MAXC];
  bit         e_drop[MAXC];
  logic [7:0] e_cdout[MAXC];
  logic [7:0] e_fdout[MAXC];

  int n_chk = 0, n_fail = 0;
  int idle_edge = 0, a_min = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: actual %0h required %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void fill_drop(input int from, input bit v);
    for (int i = from; i < MAXC; i++) e_drop[i] = v;
  endfunction

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0 && cyc < MAXC) begin
      chk("_rd",     32'(_rd),     32'(e_rdn[cyc]));
      chk("wr",      32'(wr),      32'(e_wr[cyc]));
      chk("_dtack",  32'(_dtack),  32'(e_dtn[cyc]));
      chk("ft_doe",  32'(ft_doe),  32'(e_fdoe[cyc]));
      chk("cpu_doe", 32'(cpu_doe), 32'(e_cdoe[cyc]));
      chk("tx_drop", 32'(tx_drop), 32'(e_drop[cyc]));
      if (e_cdoe[cyc]) chk("cpu_dout", 32'(cpu_dout), 32'(e_cdout[cyc]));
      if (e_fdoe[cyc]) chk("ft_dout",  32'(ft_dout),  32'(e_fdout[cyc]));
    end
  end

  // kind: 0 no select, 1 rx, 2 tx, 3 status, 4 rx+status.
  // txd: _txe goes low txd cycles after the access starts (0 = already low,
  // -1 = stays high).
  task automatic access(input int kind, input bit rwv, input logic [7:0] dat,
                        input bit rdfv, input int txd, input bit abort,
                        input int gap, input int slack,
                        output int o_e, output int o_d, output logic [7:0] o_cd);
    int A, E, D, P, R, X, T;
    logic [7:0] cd;
    o_e = 0; o_d = 0; o_cd = 8'h00;
    A = a_min + slack;
    goto(A);
    _as = 1'b0; _ds = 1'b0; rw = rwv; cpu_din = dat; ft_din = dat; _rdf = rdfv;
    _txe = (txd == 0) ? 1'b0 : 1'b1;
    sel_rx   = (kind == 1 || kind == 4);
    sel_tx   = (kind == 2);
    sel_stat = (kind == 3 || kind == 4);
    if (kind == 0) begin
      goto(A + 6);
      _as = 1'b1; _ds = 1'b1;
      a_min = A + 9;
      return;
    end
    E = imax(A + 3, idle_edge + 1);
    if (E + TO + 40 >= MAXC) begin
      $display("FAIL cycle_budget: actual %0d required < %0d", E, MAXC);
      $fatal(1);
    end
    D = E; cd = 8'hFF;
    T = (txd > 0) ? A + txd : A;
    if ((kind == 1 || kind == 4) && rwv && !rdfv) begin
      for (int i = E; i < E + RD; i++) e_rdn[i] = 1'b0;
      D = E + RD; cd = dat;
    end else if (kind == 3 && rwv) begin
      cd = {5'b0, e_drop[E-1], ~_txe, ~_rdf};
      fill_drop(E, 1'b0);
    end else if (kind == 2 && !rwv) begin
      P = (txd < 0) ? E + TO + 1 : imax(E + 1, T + 3);
      if (P - E <= TO) begin
        for (int i = E; i <= P + WR; i++) begin e_fdoe[i] = 1'b1; e_fdout[i] = dat; end
        for (int i = P; i < P + WR; i++) e_wr[i] = 1'b1;
        D = P + WR + 1;
      end else begin
        for (int i = E; i < E + TO; i++) begin e_fdoe[i] = 1'b1; e_fdout[i] = dat; end
        D = E + TO;
        fill_drop(D, 1'b1);
      end
    end
    R = abort ? E + 1 : D + gap;
    X = imax(D + 1, R + 3);
    for (int i = D; i < X; i++) begin
      e_dtn[i] = 1'b0; e_cdoe[i] = rwv; e_cdout[i] = cd;
    end
    idle_edge = X + REC;
    if (txd > 0 && T < R) begin
      goto(T);
      _txe = 1'b0;
    end
    goto(R);
    _as = 1'b1; _ds = 1'b1; sel_rx = 1'b0; sel_tx = 1'b0; sel_stat = 1'b0;
    a_min = abort ? X : R + 1;
    o_e = E; o_d = D; o_cd = cd;
  endtask

  initial begin
    int e1, d1, e2, d2, A, E, P;
    logic [7:0] cd1, cd2;
    for (int i = 0; i < MAXC; i++) begin
      e_rdn[i] = 1'b1; e_wr[i] = 1'b0; e_dtn[i] = 1'b1; e_fdoe[i] = 1'b0;
      e_cdoe[i] = 1'b0; e_drop[i] = 1'b0; e_cdout[i] = 8'h00; e_fdout[i] = 8'h00;
    end

    goto(3);
    reset = 1'b0;
    idle_edge = 3; a_min = 4;
    chk("reset_cpu_dout", 32'(cpu_dout), 32'h00);
    chk("reset_ft_dout",  32'(ft_dout),  32'h00);
    chk("reset_dtack",    32'(_dtack),   32'h1);
    chk("reset_rd",       32'(_rd),      32'h1);

    // Rx read with data available.
    access(1, 1'b1, 8'h5A, 1'b0, 0, 1'b0, 0, 2, e1, d1, cd1);
    chk("rx_latency_model", 32'(d1 - e1), 32'd3);
    chk("rx_data_dut", 32'(cpu_dout), 32'h5A);

    // Rx read, FIFO empty.
    access(1, 1'b1, 8'h33, 1'b1, 0, 1'b0, 1, 1, e1, d1, cd1);
    chk("rx_empty_model", 32'(cd1), 32'hFF);
    chk("rx_empty_dut", 32'(cpu_dout), 32'hFF);

    // Tx write, _txe already low.
    access(2, 1'b0, 8'hC3, 1'b1, 0, 1'b0, 1, 1, e1, d1, cd1);
    chk("tx_latency_model", 32'(d1 - e1), 32'd4);

    // Tx write timeout.
    access(2, 1'b0, 8'h77, 1'b1, -1, 1'b0, 0, 1, e1, d1, cd1);
    chk("timeout_model", 32'(d1 - e1), 32'd255);
    chk("tx_drop_dut", 32'(tx_drop), 32'h1);

    // Status read after the drop, then again.
    access(3, 1'b1, 8'h00, 1'b1, -1, 1'b0, 0, 1, e1, d1, cd1);
    chk("status_model", 32'(cd1), 32'h04);
    chk("status_dut", 32'(cpu_dout), 32'h04);
    access(3, 1'b1, 8'h00, 1'b1, -1, 1'b0, 0, 1, e1, d1, cd1);
    chk("status2_model", 32'(cd1), 32'h00);
    chk("status2_dut", 32'(cpu_dout), 32'h00);
    chk("tx_drop_clr_dut", 32'(tx_drop), 32'h0);

    // Back-to-back reads, second with rx and status both selected.
    access(1, 1'b1, 8'h11, 1'b0, 0, 1'b0, 0, 0, e1, d1, cd1);
    access(4, 1'b1, 8'hA5, 1'b0, 0, 1'b0, 0, 0, e2, d2, cd2);
    chk("b2b_gap_model", 32'(e2 - d1 >= REC + 3), 32'h1);
    chk("b2b_rx_dut", 32'(cpu_dout), 32'hA5);

    // Reset while wr is high.
    A = a_min + 1;
    goto(A);
    _as = 1'b0; _ds = 1'b0; rw = 1'b0; sel_tx = 1'b1; cpu_din = 8'hC3; _txe = 1'b0;
    E = imax(A + 3, idle_edge + 1);
    P = E + 1;
    for (int i = E; i <= P; i++) begin e_fdoe[i] = 1'b1; e_fdout[i] = 8'hC3; end
    e_wr[P] = 1'b1;
    goto(P);
    reset = 1'b1; _as = 1'b1; _ds = 1'b1; sel_tx = 1'b0;
    goto(P + 1);
    reset = 1'b0;
    fill_drop(P + 1, 1'b0);
    chk("rst_wr",     32'(wr),      32'h0);
    chk("rst_ft_doe", 32'(ft_doe),  32'h0);
    chk("rst_dtack",  32'(_dtack),  32'h1);
    chk("rst_ft_dout", 32'(ft_dout), 32'h00);
    idle_edge = P + 1; a_min = P + 2;
    access(1, 1'b1, 8'h3C, 1'b0, 0, 1'b0, 0, 0, e1, d1, cd1);
    chk("post_rst_rx_dut", 32'(cpu_dout), 32'h3C);

    // Access with no select is ignored.
    access(0, 1'b1, 8'h00, 1'b1, 0, 1'b0, 0, 1, e1, d1, cd1);

    // Randomized accesses.
    for (int k = 0; k < 60; k++) begin
      int kind, txd;
      bit rwv, rdfv, ab;
      kind = int'($urandom_range(0, 4));
      rwv  = 1'($urandom_range(0, 1));
      rdfv = 1'($urandom_range(0, 1));
      if (kind == 2 && !rwv) begin
        if ($urandom_range(0, 9) < 6)       txd = 0;
        else if ($urandom_range(0, 19) == 0) txd = -1;
        else                                 txd = int'($urandom_range(1, 15));
      end else begin
        txd = ($urandom_range(0, 1) == 1) ? 0 : -1;
      end
      ab = ($urandom_range(0, 5) == 0) &&
           (((kind == 1 || kind == 4) && rwv && !rdfv) || (kind == 2 && !rwv && txd == 0));
      access(kind, rwv, 8'($urandom), rdfv, txd, ab,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), e1, d1, cd1);
    end

    goto(a_min + 20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
